hazard_ctrl: RTL and testbench

- Register-dependency scoreboard and stall controller for the 5-stage pipeline core.
- Tracks the destination registers of instructions in flight downstream of ID.
- Compares each ID-stage source read against those destinations and drives the bbl stall/bubble input of the core (pc_reg, if_id, id).
- Also merges an external stall request, supports a flush, and keeps a stall performance counter.

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register-dependency scoreboard and stall controller.
// Tracks the destination registers of the instructions in EX/MEM/WB and
// stalls ID while one of its sources is still waiting to be written.
// The merged stall (bbl) is combinational, so the core sees it before the
// edge on which the ID instruction would otherwise issue.
module hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_read,
    input  logic [4:0]       id_reg1_addr,
    input  logic             id_reg2_read,
    input  logic [4:0]       id_reg2_addr,
    input  logic [4:0]       id_wd,
    input  logic             id_wreg,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             bbl,
    output logic             sb_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Scoreboard entries: index 0 entered EX this cycle, DEPTH-1 is in WB.
    logic       sb_v_reg    [DEPTH];
    logic [4:0] sb_addr_reg [DEPTH];

    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic             hz1;
    logic             hz2;

    // Value written into entry 0 when it is loaded from ID.
    logic       head_v_next;
    logic [4:0] head_addr_next;

    logic [CNT_W-1:0] stall_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sb
            // Register 0 can never be valid in an entry, so no extra guard here.
            assign match1[gi] = sb_v_reg[gi] && (sb_addr_reg[gi] == id_reg1_addr);
            assign match2[gi] = sb_v_reg[gi] && (sb_addr_reg[gi] == id_reg2_addr);

            if (gi == 0) begin : g_head
                // Head entry: loaded from ID when issuing, bubble when stalled.
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sb_v_reg[gi]    <= 1'b0;
                        sb_addr_reg[gi] <= 5'd0;
                    end else if (flush) begin
                        sb_v_reg[gi]    <= 1'b0;
                    end else begin
                        sb_v_reg[gi]    <= head_v_next;
                        sb_addr_reg[gi] <= head_addr_next;
                    end
                end
            end else begin : g_tail
                // Older entries simply follow the pipeline down one stage.
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        sb_v_reg[gi]    <= 1'b0;
                        sb_addr_reg[gi] <= 5'd0;
                    end else if (flush) begin
                        sb_v_reg[gi]    <= 1'b0;
                    end else begin
                        sb_v_reg[gi]    <= sb_v_reg[gi-1];
                        sb_addr_reg[gi] <= sb_addr_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Source hazards ignore unread ports and register 0; own id_wd is never compared.
    always_comb begin
        hz1 = id_reg1_read && (id_reg1_addr != 5'd0) && (|match1);
        hz2 = id_reg2_read && (id_reg2_addr != 5'd0) && (|match2);
        bbl = hz1 | hz2 | ext_stall;
    end

    // Head load value: a stalled cycle inserts a bubble that writes nothing.
    always_comb begin
        head_v_next    = 1'b0;
        head_addr_next = 5'd0;
        if (!bbl) begin
            head_v_next    = id_wreg && (id_wd != 5'd0);
            head_addr_next = id_wd;
        end
    end

    // Busy whenever any tracked write is still in flight.
    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_busy = sb_busy | sb_v_reg[i];
        end
    end

    // Saturating count of stalled cycles; flush does not touch it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (bbl && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus for hazard_ctrl with a queue of
// expected outputs, checked on the falling edge before each issuing edge.
// A second instance with a 4-bit counter shares all inputs to check saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_reg1_read;
    logic [4:0]  id_reg1_addr;
    logic        id_reg2_read;
    logic [4:0]  id_reg2_addr;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic        ext_stall;
    logic        flush;
    logic        bbl;
    logic        sb_busy;
    logic [31:0] stall_cnt;
    logic        bbl4;
    logic        sb_busy4;
    logic [3:0]  stall_cnt4;

    hazard_ctrl #(.DEPTH(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .id_wd(id_wd), .id_wreg(id_wreg),
        .ext_stall(ext_stall), .flush(flush),
        .bbl(bbl), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.DEPTH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .id_wd(id_wd), .id_wreg(id_wreg),
        .ext_stall(ext_stall), .flush(flush),
        .bbl(bbl4), .sb_busy(sb_busy4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        bbl;
        logic        busy;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    // Present one ID instruction (held unchanged while it is stalled).
    task automatic instr(input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2,
                         input logic [4:0] wd, input logic wr);
        id_reg1_read = r1; id_reg1_addr = a1;
        id_reg2_read = r2; id_reg2_addr = a2;
        id_wd        = wd; id_wreg      = wr;
    endtask

    task automatic nop();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    // One cycle: queue the expectation, check before the edge, then take the edge.
    task automatic tick(input string tag, input logic e_bbl, input logic e_busy,
                        input logic [31:0] e_cnt);
        exp_t e;
        exp_t g;
        e.tag  = tag;
        e.bbl  = e_bbl;
        e.busy = e_busy;
        e.cnt  = e_cnt;
        e.cnt4 = (e_cnt > 32'd15) ? 4'hF : e_cnt[3:0];
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        $display("[TB] %s: bbl=%0b busy=%0b cnt=%0d cnt4=%0d (want %0b %0b %0d %0d)",
                 g.tag, bbl, sb_busy, stall_cnt, stall_cnt4, g.bbl, g.busy, g.cnt, g.cnt4);
        tests_run++;
        assert (bbl === g.bbl) else begin
            tests_failed++;
            $error("FAIL %s bbl got %0b want %0b", g.tag, bbl, g.bbl);
        end
        tests_run++;
        assert (sb_busy === g.busy) else begin
            tests_failed++;
            $error("FAIL %s sb_busy got %0b want %0b", g.tag, sb_busy, g.busy);
        end
        tests_run++;
        assert (stall_cnt === g.cnt) else begin
            tests_failed++;
            $error("FAIL %s stall_cnt got %0d want %0d", g.tag, stall_cnt, g.cnt);
        end
        tests_run++;
        assert (stall_cnt4 === g.cnt4) else begin
            tests_failed++;
            $error("FAIL %s stall_cnt4 got %0d want %0d", g.tag, stall_cnt4, g.cnt4);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        ext_stall = 1'b0;
        flush     = 1'b0;
        nop();
        @(posedge clk);
        #1;
        tick("reset", 1'b0, 1'b0, 0);
        rst = 1'b1;

        // Back-to-back dependency: 3 stall cycles.
        instr(1, 0, 0, 0, 1, 1);          tick("d1_ori", 0, 0, 0);
        instr(1, 1, 1, 0, 2, 1);          tick("d1_s1", 1, 1, 0);
                                          tick("d1_s2", 1, 1, 1);
                                          tick("d1_s3", 1, 1, 2);
                                          tick("d1_issue", 0, 0, 3);

        // One NOP between: 2 stall cycles.
        instr(1, 0, 0, 0, 1, 1);          tick("d2_ori", 0, 1, 3);
        nop();                            tick("d2_nop", 0, 1, 3);
        instr(1, 1, 1, 1, 2, 1);          tick("d2_s1", 1, 1, 3);
                                          tick("d2_s2", 1, 1, 4);
                                          tick("d2_issue", 0, 0, 5);

        // Two NOPs between: 1 stall cycle.
        instr(1, 0, 0, 0, 1, 1);          tick("d3_ori", 0, 1, 5);
        nop();                            tick("d3_nop1", 0, 1, 5);
                                          tick("d3_nop2", 0, 1, 5);
        instr(1, 1, 1, 1, 2, 1);          tick("d3_s1", 1, 1, 5);
                                          tick("d3_issue", 0, 0, 6);

        // Three NOPs between: no stall.
        instr(1, 0, 0, 0, 1, 1);          tick("d4_ori", 0, 1, 6);
        nop();                            tick("d4_nop1", 0, 1, 6);
                                          tick("d4_nop2", 0, 1, 6);
                                          tick("d4_nop3", 0, 1, 6);
        instr(1, 1, 1, 1, 2, 1);          tick("d4_issue", 0, 0, 6);
        nop();                            tick("d4_drain1", 0, 1, 6);
                                          tick("d4_drain2", 0, 1, 6);
                                          tick("d4_drain3", 0, 1, 6);

        // Register 0 never hazards; own destination never compared.
        instr(1, 0, 0, 0, 0, 1);          tick("r0_ori", 0, 0, 6);
        instr(1, 0, 1, 0, 3, 1);          tick("r0_addu", 0, 0, 6);
        instr(1, 4, 0, 0, 4, 1);          tick("self_addi", 0, 1, 6);
        nop();                            tick("r0_drain1", 0, 1, 6);
                                          tick("r0_drain2", 0, 1, 6);
                                          tick("r0_drain3", 0, 1, 6);

        // Source 2 hazard; unread source 1 with matching address ignored.
        instr(1, 0, 0, 0, 5, 1);          tick("s2_ori", 0, 0, 6);
        instr(0, 5, 0, 0, 6, 0);          tick("s2_rd1off", 0, 1, 6);
        instr(0, 0, 1, 5, 7, 1);          tick("s2_s1", 1, 1, 6);
                                          tick("s2_s2", 1, 1, 7);
                                          tick("s2_issue", 0, 0, 8);
        nop();                            tick("s2_drain1", 0, 1, 8);
                                          tick("s2_drain2", 0, 1, 8);
                                          tick("s2_drain3", 0, 1, 8);

        // External stall for 4 cycles; scoreboard keeps draining.
        instr(1, 0, 0, 0, 9, 1);          tick("ext_ori", 0, 0, 8);
        instr(1, 1, 0, 0, 10, 1);
        ext_stall = 1'b1;                 tick("ext_1", 1, 1, 8);
                                          tick("ext_2", 1, 1, 9);
                                          tick("ext_3", 1, 1, 10);
                                          tick("ext_4", 1, 0, 11);
        ext_stall = 1'b0;                 tick("ext_issue", 0, 0, 12);
        nop();                            tick("ext_drain1", 0, 1, 12);
                                          tick("ext_drain2", 0, 1, 12);
                                          tick("ext_drain3", 0, 1, 12);

        // Flush during a pending hazard clears the scoreboard.
        instr(1, 0, 0, 0, 1, 1);          tick("fl_ori", 0, 0, 12);
        instr(1, 1, 1, 1, 2, 1);
        flush = 1'b1;                     tick("fl_cycle", 1, 1, 12);
        flush = 1'b0;                     tick("fl_after", 0, 0, 13);

        // Reset in the middle of a stall.
        instr(1, 2, 0, 0, 4, 1);          tick("rs_s1", 1, 1, 13);
        rst = 1'b0;                       tick("rs_cycle", 1, 1, 14);
        rst = 1'b1;                       tick("rs_after", 0, 0, 0);

        // 20 forced stall cycles: wide counter counts, 4-bit one saturates at 15.
        nop();
        ext_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick($sformatf("sat_%0d", i), 1'b1, (i < 3) ? 1'b1 : 1'b0, i);
        end
        ext_stall = 1'b0;                 tick("sat_end", 0, 0, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
